updn_counter_sequencer: RTL and testbench
=========================================

Name: updn_counter_sequencer

Overview:
Shares one 16-bit up/down counter between NREQ requesters. Each requester issues one command: load a value, count up N steps, or count down N steps. The block arbitrates round-robin and drives the counter's ld_cnt/count_enb/updn_cnt/data_in for exactly the required cycles. It returns a per-requester done pulse with the final counter value.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 16, counter/data width

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous reset, active-high
req  in  NREQ  request per requester; held high until matching done
cmd  in  2*NREQ  per-requester command, slice i = cmd[2i+1:2i]; 00 LOAD, 01 UP, 10 DOWN, 11 NOP
val  in  W*NREQ  per-requester operand, slice i = val[W*i+W-1:W*i]; load value for LOAD, step count for UP/DOWN
gnt  out  NREQ  one-hot grant, high from ISSUE through DONE
done  out  NREQ  one-cycle completion pulse to granted requester
result  out  W  counter value captured at completion, held until next completion
busy  out  1  high whenever state != IDLE
ld_cnt  out  1  counter load, active-low (0 = load data_in)
count_enb  out  1  counter count enable
updn_cnt  out  1  counter direction, 1 = up
data_in  out  W  counter load data
data_out  in  W  counter current value

Behaviour:
- Counter contract:
  - ld_cnt=0: counter loads data_in at the next edge.
  - ld_cnt=1 and count_enb=1: counter steps ±1 per updn_cnt, wrapping modulo 2^W.
  - Otherwise: counter holds.
- Reset values, also applied on rst asserted in any state:
  - ld_cnt=1, count_enb=0, updn_cnt=0, data_in=0.
  - gnt=0, done=0, result=0, busy=0.
  - State=IDLE, rr_ptr=0, step counter=0.
- Reset mid-operation: the command is abandoned, no done is issued, and the counter control outputs are idle from the cycle after rst.
- States: IDLE, ISSUE, LOAD, RUN, DONE.
- IDLE:
  - If any req is high, pick the first set bit searching upward from rst_ptr (wrapping).
  - Register the grant index, its cmd, and its val; go to ISSUE.
  - req sampled at edge t gives gnt high in cycle t+1.
- ISSUE, one cycle, no counter activity:
  - LOAD -> LOAD.
  - UP/DOWN with val=0 -> DONE.
  - UP/DOWN with val>0 -> RUN; load step counter with val.
  - NOP -> DONE.
- LOAD, one cycle: ld_cnt=0, data_in=latched val, count_enb=0. Next state DONE.
- RUN:
  - ld_cnt=1, count_enb=1, updn_cnt=(cmd==UP).
  - Step counter decrements each cycle; leave to DONE when it reaches 1.
  - count_enb is high for exactly val cycles, contiguous.
- DONE, one cycle:
  - Counter control idle: ld_cnt=1, count_enb=0.
  - done[g]=1 and result=data_out; data_out already reflects the last step or load.
  - rr_ptr=(g+1) mod NREQ. Next state IDLE; gnt drops when IDLE is entered.
- Latency from IDLE acceptance: LOAD = 3 cycles to done; UP/DOWN N = N+2; NOP or N=0 = 2.
- Request handling:
  - req changes and cmd/val changes after acceptance are ignored until done. Operands are latched in IDLE.
  - A requester must drop req the cycle after done. If req is still high, it is a new request, arbitrated fairly, lowest priority.
- Minimum 1 IDLE cycle between commands, so back-to-back commands are spaced ≥1 cycle.
- Wrap-around is the counter's: UP from 16'hFFFF gives 16'h0000 and is not an error.
- count_enb and ld_cnt=0 are never active in the same cycle.
- Outputs ld_cnt, count_enb, updn_cnt, data_in, gnt, done, result, busy are all registered.

Test Plan:
- rst high 2 cycles then low, no req -> all outputs at reset values; busy=0; ld_cnt=1 throughout.
- req[0], LOAD val=16'h1234 -> ld_cnt=0 exactly 1 cycle with data_in=16'h1234; done[0] 3 cycles after acceptance; result=16'h1234.
- After loading 16'hFFFE, req[1] UP val=3 -> count_enb high exactly 3 cycles, updn_cnt=1; result=16'h0001 (wrap).
- req[2] DOWN val=0, and separately NOP -> no ld_cnt/count_enb activity; done 2 cycles after acceptance; result=current data_out.
- req[0..3] all high simultaneously with rr_ptr=0, each dropping req after done -> grant order 0,1,2,3. Then req[1],req[3] high with rr_ptr=0 -> 1 then 3.
- rst asserted during RUN of UP val=10 after 4 steps -> next cycle count_enb=0, gnt=0, no done pulse, state IDLE.

Source files
------------

// File: rtl/updn_counter_sequencer_if.sv
// Requester-side bundle for the up/down counter sequencer.
// Master drives request/command/operand; slave returns grant/done/result.
interface updn_counter_sequencer_if #(
  parameter int NREQ = 4,
  parameter int W    = 16
);
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] cmd;
  logic [W*NREQ-1:0] val;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [W-1:0]      result;

  modport master (output req, cmd, val, input gnt, done, result);
  modport slave  (input req, cmd, val, output gnt, done, result);
endinterface

// File: rtl/updn_counter_sequencer.sv
// Round-robin sequencer sharing one W-bit up/down counter between NREQ requesters.
// LOAD completes in 3 cycles, UP/DOWN N in N+2, NOP or N=0 in 2; all outputs registered.
module updn_counter_sequencer #(
  parameter int NREQ = 4,
  parameter int W    = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  updn_counter_sequencer_if.slave        bus,
  output logic                           busy,
  output logic                           ld_cnt,
  output logic                           count_enb,
  output logic                           updn_cnt,
  output logic [W-1:0]                   data_in,
  input  logic [W-1:0]                   data_out
);

  localparam int IW = $clog2(NREQ);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] C_LOAD = 2'b00;
  localparam logic [1:0] C_UP   = 2'b01;
  localparam logic [1:0] C_DOWN = 2'b10;

  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  logic [2:0]    state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] gidx;
  logic [1:0]    lcmd;
  logic [W-1:0]  lval;
  logic [W-1:0]  step;

  logic          found;
  logic [IW-1:0] pick;
  int            k;

  // First requester at or above rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    k     = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = int'(rr_ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      if (!found && bus.req[k]) begin
        found = 1'b1;
        pick  = IW'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      gidx       <= '0;
      lcmd       <= 2'b00;
      lval       <= '0;
      step       <= '0;
      bus.gnt    <= '0;
      bus.done   <= '0;
      bus.result <= '0;
      busy       <= 1'b0;
      ld_cnt     <= 1'b1;
      count_enb  <= 1'b0;
      updn_cnt   <= 1'b0;
      data_in    <= '0;
    end else begin
      bus.done <= '0;
      case (state)
        S_IDLE: begin
          if (found) begin
            gidx    <= pick;
            lcmd    <= bus.cmd[2*int'(pick) +: 2];
            lval    <= bus.val[W*int'(pick) +: W];
            bus.gnt <= ONE_HOT0 << pick;
            busy    <= 1'b1;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (lcmd == C_LOAD) begin
            ld_cnt  <= 1'b0;
            data_in <= lval;
            state   <= S_LOAD;
          end else if ((lcmd == C_UP || lcmd == C_DOWN) && lval != '0) begin
            step      <= lval;
            count_enb <= 1'b1;
            updn_cnt  <= (lcmd == C_UP);
            state     <= S_RUN;
          end else begin
            // Counter is idle, so its current value is already final.
            bus.result <= data_out;
            bus.done   <= bus.gnt;
            state      <= S_DONE;
          end
        end
        S_LOAD: begin
          ld_cnt     <= 1'b1;
          bus.result <= lval;
          bus.done   <= bus.gnt;
          state      <= S_DONE;
        end
        S_RUN: begin
          step <= step - W'(1);
          if (step == W'(1)) begin
            // The final step lands on this edge, so result tracks data_out in DONE.
            count_enb  <= 1'b0;
            bus.result <= updn_cnt ? data_out + W'(1) : data_out - W'(1);
            bus.done   <= bus.gnt;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          bus.gnt <= '0;
          busy    <= 1'b0;
          rr_ptr  <= (int'(gidx) == NREQ - 1) ? '0 : gidx + IW'(1);
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_updn_counter_sequencer.sv
// Scoreboard bench for updn_counter_sequencer with a behavioural counter model.
module tb_updn_counter_sequencer;
  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam logic [1:0] LOAD = 2'b00, UP = 2'b01, DOWN = 2'b10, NOP = 2'b11;

  logic clk, rst;
  logic busy, ld_cnt, count_enb, updn_cnt;
  logic [W-1:0] data_in, data_out;
  logic [W-1:0] cnt_q = '0;

  updn_counter_sequencer_if #(.NREQ(NREQ), .W(W)) bus();

  updn_counter_sequencer #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .ld_cnt(ld_cnt),
    .count_enb(count_enb), .updn_cnt(updn_cnt), .data_in(data_in), .data_out(data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (!ld_cnt) cnt_q <= data_in;
    else if (count_enb) cnt_q <= updn_cnt ? cnt_q + 16'd1 : cnt_q - 16'd1;
  end
  assign data_out = cnt_q;

  typedef struct {
    int          idx;
    logic [15:0] res;
    int          lat;
    int          n_en;
    int          n_ld;
    logic        up;
  } exp_t;
  exp_t sbq[$];

  int checks = 0, errors = 0;
  int cyc = 0, gstart = 0, n_en = 0, n_ld = 0, done_cnt = 0;
  logic [NREQ-1:0] prev_gnt = '0;
  logic [15:0] din_seen = '0;
  logic up_seen = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: observes DUT outputs and pops the scoreboard on every done.
  always @(negedge clk) begin
    if (rst) begin
      prev_gnt = '0;
    end else begin
      chk("ld_and_en_exclusive", {31'd0, (!ld_cnt && count_enb)}, 32'd0);
      if (bus.gnt != '0 && prev_gnt == '0) begin
        gstart = cyc; n_en = 0; n_ld = 0;
      end
      if (count_enb) begin n_en++; up_seen = updn_cnt; end
      if (!ld_cnt) begin n_ld++; din_seen = data_in; end
      if (bus.done != '0) begin
        exp_t e;
        done_cnt++;
        if (sbq.size() == 0) begin
          chk("unexpected_done", {28'd0, bus.done}, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("done_onehot", {28'd0, bus.done}, 32'd1 << e.idx);
          chk("gnt_at_done", {28'd0, bus.gnt}, 32'd1 << e.idx);
          chk("result", {16'd0, bus.result}, {16'd0, e.res});
          chk("latency", cyc - gstart + 1, e.lat);
          chk("count_enb_cycles", n_en, e.n_en);
          chk("ld_cycles", n_ld, e.n_ld);
          if (e.n_en > 0) chk("updn_dir", {31'd0, up_seen}, {31'd0, e.up});
          if (e.n_ld > 0) chk("load_data_in", {16'd0, din_seen}, {16'd0, e.res});
        end
      end
      prev_gnt = bus.gnt;
    end
  end

  task automatic set_cmd(int i, logic [1:0] c, logic [15:0] v);
    bus.cmd[2*i +: 2] = c;
    bus.val[W*i +: W] = v;
  endtask

  task automatic expect_txn(int i, logic [1:0] c, logic [15:0] v, logic [15:0] res);
    exp_t e;
    e.idx = i; e.res = res; e.up = (c == UP); e.n_en = 0; e.n_ld = 0; e.lat = 2;
    if (c == LOAD) begin e.lat = 3; e.n_ld = 1; end
    else if (c != NOP && v != 0) begin e.lat = int'(v) + 2; e.n_en = int'(v); end
    sbq.push_back(e);
  endtask

  task automatic wait_done(logic [NREQ-1:0] mask);
    logic [NREQ-1:0] pend = mask;
    int budget = 300;
    while (pend != '0 && budget > 0) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++)
        if (bus.done[i] && pend[i]) begin bus.req[i] = 1'b0; pend[i] = 1'b0; end
      budget--;
    end
    if (pend != '0) chk("wait_done_timeout", {28'd0, pend}, 32'd0);
  endtask

  task automatic one(int i, logic [1:0] c, logic [15:0] v, logic [15:0] res);
    @(negedge clk);
    set_cmd(i, c, v);
    expect_txn(i, c, v, res);
    bus.req[i] = 1'b1;
    wait_done(NREQ'(1) << i);
  endtask

  initial begin
    int steps, budget, snap;
    rst = 1'b1; bus.req = '0; bus.cmd = '0; bus.val = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", {28'd0, bus.gnt}, 32'd0);
    chk("rst_done", {28'd0, bus.done}, 32'd0);
    chk("rst_result", {16'd0, bus.result}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ld_cnt", {31'd0, ld_cnt}, 32'd1);
    chk("rst_count_enb", {31'd0, count_enb}, 32'd0);
    chk("rst_updn", {31'd0, updn_cnt}, 32'd0);
    chk("rst_data_in", {16'd0, data_in}, 32'd0);

    one(0, LOAD, 16'h1234, 16'h1234);
    one(0, LOAD, 16'hFFFE, 16'hFFFE);
    one(1, UP,   16'd3,    16'h0001);
    one(2, DOWN, 16'd0,    16'h0001);
    one(3, NOP,  16'd5,    16'h0001);

    // rr_ptr is back at 0: all four at once must be served 0,1,2,3.
    @(negedge clk);
    set_cmd(0, LOAD, 16'h0010); set_cmd(1, UP, 16'd2);
    set_cmd(2, DOWN, 16'd5);    set_cmd(3, LOAD, 16'hABCD);
    expect_txn(0, LOAD, 16'h0010, 16'h0010);
    expect_txn(1, UP,   16'd2,    16'h0012);
    expect_txn(2, DOWN, 16'd5,    16'h000D);
    expect_txn(3, LOAD, 16'hABCD, 16'hABCD);
    bus.req = 4'b1111;
    wait_done(4'b1111);

    @(negedge clk);
    set_cmd(1, UP, 16'd1); set_cmd(3, DOWN, 16'd3);
    expect_txn(1, UP,   16'd1, 16'hABCE);
    expect_txn(3, DOWN, 16'd3, 16'hABCB);
    bus.req = 4'b1010;
    wait_done(4'b1010);

    // Reset in the middle of a 10-step UP after 4 steps.
    @(negedge clk);
    set_cmd(0, UP, 16'd10);
    bus.req[0] = 1'b1;
    steps = 0; budget = 50;
    while (steps < 4 && budget > 0) begin
      @(negedge clk);
      if (count_enb) steps++;
      budget--;
    end
    chk("run_steps_seen", steps, 4);
    snap = done_cnt;
    rst = 1'b1; bus.req = '0;
    @(negedge clk);
    chk("midrst_count_enb", {31'd0, count_enb}, 32'd0);
    chk("midrst_gnt", {28'd0, bus.gnt}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ld_cnt", {31'd0, ld_cnt}, 32'd1);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("midrst_no_done", done_cnt - snap, 0);
    chk("midrst_idle", {31'd0, busy}, 32'd0);

    budget = 100;
    while (sbq.size() != 0 && budget > 0) begin @(negedge clk); budget--; end
    chk("scoreboard_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
